// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run-control sequencer for the 4-digit BCD stopwatch counter
module stopwatch_ctrl #(
    parameter int ALARM_TICKS = 5000,
    parameter int ALARM_W     = 16
) (
    input  logic       clk_used,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       adj_tick,
    input  logic       btn_go,
    input  logic       btn_clr,
    input  logic       btn_set,
    input  logic       btn_dir,
    input  logic       adj,
    input  logic       alarm_ack,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    output logic       cnt_rst,
    output logic       cnt_run,
    output logic       cnt_dir,
    output logic       alarm,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SET   = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic               dir_q;
    logic [ALARM_W-1:0] alarm_cnt;

    logic               at_9999;
    logic               at_0000;
    logic               term;
    logic               term_run;

    logic [2:0]         state_nx;
    logic               dir_nx;
    logic [ALARM_W-1:0] alarm_cnt_nx;
    logic               rst_nx;
    logic               run_nx;

    assign at_9999 = (digit1 == 4'd9) && (digit2 == 4'd9) && (digit3 == 4'd9) && (digit4 == 4'd9);
    assign at_0000 = (digit1 == 4'd0) && (digit2 == 4'd0) && (digit3 == 4'd0) && (digit4 == 4'd0);
    assign term    = cnt_dir ? at_9999 : at_0000;
    // Run gating uses the RUN direction so a tick arriving with the entry into RUN
    // (e.g. from SET, where cnt_dir is still forced up) is judged correctly.
    assign term_run = dir_q ? at_9999 : at_0000;

    always_comb begin
        state_nx     = state;
        dir_nx       = dir_q;
        alarm_cnt_nx = alarm_cnt;
        rst_nx       = 1'b0;
        if (state > DONE || btn_clr) begin
            state_nx = IDLE;
            rst_nx   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_go)       state_nx = RUN;
                    else if (btn_set) state_nx = SET;
                    else if (btn_dir) dir_nx   = ~dir_q;
                end
                SET: begin
                    if (btn_go)       state_nx = RUN;
                    else if (btn_set) state_nx = IDLE;
                end
                RUN: begin
                    if (btn_go)    state_nx = PAUSE;
                    else if (term) state_nx = DONE;
                end
                PAUSE: begin
                    if (btn_go)       state_nx = RUN;
                    else if (btn_dir) dir_nx   = ~dir_q;
                end
                DONE: begin
                    if (btn_go || alarm_ack) begin
                        state_nx = IDLE;
                    end else if (tick) begin
                        if (alarm_cnt == ALARM_W'(ALARM_TICKS - 1)) state_nx = IDLE;
                        else alarm_cnt_nx = alarm_cnt + ALARM_W'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        if (state_nx == DONE && state != DONE) alarm_cnt_nx = '0;
        run_nx = (state_nx == RUN && tick && !term_run) ||
                 (state_nx == SET && adj && adj_tick && !at_9999);
    end

    always_ff @(posedge clk_used or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt_rst   <= 1'b1;
            cnt_run   <= 1'b0;
            cnt_dir   <= 1'b1;
            dir_q     <= 1'b1;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            state     <= state_nx;
            cnt_rst   <= rst_nx;
            cnt_run   <= run_nx;
            cnt_dir   <= (state_nx == SET) ? 1'b1 : dir_nx;
            dir_q     <= dir_nx;
            alarm     <= (state_nx == DONE);
            alarm_cnt <= alarm_cnt_nx;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed bench for stopwatch_ctrl with a behavioural BCD counter
module tb_stopwatch_ctrl;

    logic       clk_used = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       adj_tick = 1'b0;
    logic       btn_go = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_dir = 1'b0;
    logic       adj = 1'b0;
    logic       alarm_ack = 1'b0;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       cnt_rst, cnt_run, cnt_dir, alarm;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int run_count = 0;
    int val = 0;
    logic load_req = 1'b0;
    int   load_val = 0;
    int   snap;

    stopwatch_ctrl #(.ALARM_TICKS(3), .ALARM_W(4)) dut (
        .clk_used (clk_used),
        .rst_n    (rst_n),
        .tick     (tick),
        .adj_tick (adj_tick),
        .btn_go   (btn_go),
        .btn_clr  (btn_clr),
        .btn_set  (btn_set),
        .btn_dir  (btn_dir),
        .adj      (adj),
        .alarm_ack(alarm_ack),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .digit4   (digit4),
        .cnt_rst  (cnt_rst),
        .cnt_run  (cnt_run),
        .cnt_dir  (cnt_dir),
        .alarm    (alarm),
        .state    (state)
    );

    always #5 clk_used = ~clk_used;

    // Counter model: clear/step on the clock edge, digits are a decimal view of val.
    always @(posedge clk_used) begin
        if (load_req) val <= load_val;
        else if (cnt_rst) val <= 0;
        else if (cnt_run) begin
            if (cnt_dir) val <= (val == 9999) ? 0 : val + 1;
            else         val <= (val == 0) ? 9999 : val - 1;
        end
        if (cnt_run) run_count <= run_count + 1;
    end

    assign digit1 = 4'((val / 1000) % 10);
    assign digit2 = 4'((val / 100) % 10);
    assign digit3 = 4'((val / 10) % 10);
    assign digit4 = 4'(val % 10);

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 0=go 1=clr 2=set 3=dir 4=ack 5=clr+go
    task automatic press(input int which);
        @(negedge clk_used);
        case (which)
            0: btn_go = 1'b1;
            1: btn_clr = 1'b1;
            2: btn_set = 1'b1;
            3: btn_dir = 1'b1;
            4: alarm_ack = 1'b1;
            default: begin btn_clr = 1'b1; btn_go = 1'b1; end
        endcase
        @(negedge clk_used);
        {btn_go, btn_clr, btn_set, btn_dir, alarm_ack} = '0;
    endtask

    task automatic do_ticks(input int n, input bit fast);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_used);
            if (fast) adj_tick = 1'b1; else tick = 1'b1;
            @(negedge clk_used);
            adj_tick = 1'b0;
            tick = 1'b0;
            repeat (3) @(negedge clk_used);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_used);
        check("rst_cnt_rst", cnt_rst, 1);
        check("rst_state", state, 0);
        check("rst_cnt_dir", cnt_dir, 1);
        check("rst_alarm", alarm, 0);
        rst_n = 1'b1;
        @(negedge clk_used);
        check("post_rst_cnt_rst", cnt_rst, 0);
        check("post_rst_val", val, 0);

        press(0);
        check("go_run", state, 2);
        snap = run_count;
        do_ticks(12, 1'b0);
        check("up12_runs", run_count - snap, 12);
        check("up12_val", val, 12);
        press(0);
        check("pause_state", state, 3);
        snap = run_count;
        do_ticks(2, 1'b0);
        check("pause_no_run", run_count - snap, 0);
        press(0);
        check("resume_state", state, 2);
        do_ticks(1, 1'b0);
        check("resume_val", val, 13);

        press(5);
        check("clrgo_state", state, 0);
        check("clrgo_cnt_rst", cnt_rst, 1);
        @(negedge clk_used);
        check("clrgo_cnt_rst_drop", cnt_rst, 0);
        check("clrgo_val", val, 0);

        press(2);
        check("set_state", state, 1);
        check("set_dir", cnt_dir, 1);
        adj = 1'b1;
        snap = run_count;
        do_ticks(25, 1'b1);
        adj = 1'b0;
        check("set_runs", run_count - snap, 25);
        check("set_val", val, 25);
        press(2);
        check("set_exit", state, 0);
        press(3);
        check("dir_down", cnt_dir, 0);
        press(0);
        check("down_run", state, 2);
        snap = run_count;
        do_ticks(25, 1'b0);
        check("down_val", val, 0);
        check("down_state_done", state, 4);
        check("down_alarm", alarm, 1);
        check("down_runs", run_count - snap, 25);

        do_ticks(2, 1'b0);
        check("to_two_ticks", state, 4);
        do_ticks(1, 1'b0);
        check("to_three_ticks", state, 0);
        check("to_alarm_off", alarm, 0);
        check("to_digits_kept", val, 0);

        snap = run_count;
        press(0);
        @(negedge clk_used);
        check("term_entry_done", state, 4);
        check("term_entry_alarm", alarm, 1);
        do_ticks(1, 1'b0);
        check("ack_pre_state", state, 4);
        press(4);
        check("ack_state", state, 0);
        check("ack_alarm", alarm, 0);
        check("term_entry_runs", run_count - snap, 0);

        @(negedge clk_used);
        load_req = 1'b1;
        load_val = 9998;
        @(negedge clk_used);
        load_req = 1'b0;
        press(3);
        check("up_dir", cnt_dir, 1);
        press(0);
        snap = run_count;
        do_ticks(1, 1'b0);
        check("top_val", val, 9999);
        check("top_done", state, 4);
        check("top_runs", run_count - snap, 1);
        do_ticks(2, 1'b0);
        check("top_no_more_runs", run_count - snap, 1);
        check("top_still_done", state, 4);

        #2 rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_cnt_rst", cnt_rst, 1);
        check("arst_cnt_run", cnt_run, 0);
        check("arst_cnt_dir", cnt_dir, 1);
        check("arst_alarm", alarm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
